// File: rtl/reg_bus_master.sv
// reg_bus_master: converts a valid/ready command stream into single
// transactions on the 32-bit register bus and returns one response per command.
// Optional: define REG_BUS_ALIGN_CHECK_EN to reject misaligned addresses
// (cmd_addr[1:0] != 0) without issuing them on the bus.
module reg_bus_master #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_wstrb,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  output logic [DATA_W/8-1:0] bus_wstrb,
  output logic                bus_we,
  output logic                bus_re,
  input  logic [DATA_W-1:0]   bus_rdata,
  input  logic                bus_ready,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err
);

  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t              state, state_nx;
  logic [CNT_W-1:0]    cnt, cnt_nx;
  logic [ADDR_W-1:0]   addr_nx;
  logic [DATA_W-1:0]   wdata_nx;
  logic [DATA_W/8-1:0] wstrb_nx;
  logic                we_nx, re_nx;
  logic [DATA_W-1:0]   rdata_nx;
  logic                err_nx;
  logic                accept;

  // Handshake outputs decoded from state; cmd_ready is held low while in reset.
  assign cmd_ready = (state == IDLE) && !rst;
  assign rsp_valid = (state == RESP);
  assign accept    = cmd_valid && cmd_ready;

  // Next-state and next-output computation for all registered signals.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    addr_nx  = bus_addr;
    wdata_nx = bus_wdata;
    wstrb_nx = bus_wstrb;
    we_nx    = bus_we;
    re_nx    = bus_re;
    rdata_nx = rsp_rdata;
    err_nx   = rsp_err;
    unique case (state)
      IDLE: begin
        we_nx = 1'b0;
        re_nx = 1'b0;
        if (accept) begin
`ifdef REG_BUS_ALIGN_CHECK_EN
          if (cmd_addr[1:0] != 2'b00) begin
            rdata_nx = '0;
            err_nx   = 1'b1;
            state_nx = RESP;
          end else begin
            addr_nx  = cmd_addr;
            wdata_nx = cmd_wdata;
            wstrb_nx = cmd_wstrb;
            we_nx    = cmd_write;
            re_nx    = !cmd_write;
            cnt_nx   = '0;
            state_nx = BUSY;
          end
`else
          addr_nx  = cmd_addr;
          wdata_nx = cmd_wdata;
          wstrb_nx = cmd_wstrb;
          we_nx    = cmd_write;
          re_nx    = !cmd_write;
          cnt_nx   = '0;
          state_nx = BUSY;
`endif
        end
      end
      BUSY: begin
        // Success wins over the timeout terminal count in the same cycle.
        if (bus_ready) begin
          we_nx    = 1'b0;
          re_nx    = 1'b0;
          rdata_nx = bus_re ? bus_rdata : '0;
          err_nx   = 1'b0;
          state_nx = RESP;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          we_nx    = 1'b0;
          re_nx    = 1'b0;
          rdata_nx = '0;
          err_nx   = 1'b1;
          state_nx = RESP;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rdata_nx = '0;
          err_nx   = 1'b0;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_wstrb <= '0;
      bus_we    <= 1'b0;
      bus_re    <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      bus_addr  <= addr_nx;
      bus_wdata <= wdata_nx;
      bus_wstrb <= wstrb_nx;
      bus_we    <= we_nx;
      bus_re    <= re_nx;
      rsp_rdata <= rdata_nx;
      rsp_err   <= err_nx;
    end
  end

endmodule
